apb_arbiter: RTL and testbench

- Round-robin arbiter that shares one APB slave bus between NUM_M APB masters, e.g. several Computer-style read/sum requesters on one register bank.
- Each master sees a standard APB slave port. Only the granted master's transfer is forwarded to the slave. Other masters are held in wait by pready low.
- Grant is per transfer: it is taken at transfer start and released after the slave completes the transfer.

---
 rtl/apb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_apb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB slave between NUM_M APB masters, one grant per transfer.
// Optional macro ARB_TIMEOUT_EN adds an ACCESS-phase timeout with a timeout_o pulse.
module apb_arbiter #(
  parameter int NUM_M       = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,
  input  logic [NUM_M-1:0]        m_psel_i,
  input  logic [NUM_M-1:0]        m_penable_i,
  input  logic [NUM_M-1:0]        m_pwrite_i,
  input  logic [NUM_M*ADDR_W-1:0] m_paddr_i,
  input  logic [NUM_M*DATA_W-1:0] m_pwdata_i,
  output logic [DATA_W-1:0]       m_prdata_o,
  output logic [NUM_M-1:0]        m_pready_o,
  output logic [NUM_M-1:0]        m_pslverr_o,
  output logic                    s_psel_o,
  output logic                    s_penable_o,
  output logic                    s_pwrite_o,
  output logic [ADDR_W-1:0]       s_paddr_o,
  output logic [DATA_W-1:0]       s_pwdata_o,
  input  logic [DATA_W-1:0]       s_prdata_i,
  input  logic                    s_pready_i,
  input  logic                    s_pslverr_i,
  output logic [NUM_M-1:0]        grant_o,
`ifdef ARB_TIMEOUT_EN
  output logic                    timeout_o,
`endif
  output logic                    busy_o
);

  // state    | meaning
  // S_IDLE   | no transfer; arbitrate and capture the winner's request
  // S_SETUP  | slave psel=1, penable=0
  // S_ACCESS | slave psel=1, penable=1; wait for s_pready_i
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d, paddr_sel;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d, pwdata_sel;
  logic               pwrite_q, pwrite_d, pwrite_sel;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_M-1:0]   win_oh;
  logic               timeout;
  logic               done;
  logic               unused_penable;

  assign unused_penable = ^m_penable_i;

  // First requester scanning upward from ptr+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      for (int j = 0; j < NUM_M; j++) begin
        if (!win_found && m_psel_i[j] && (((int'(ptr_q) + i) % NUM_M) == j)) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(j);
          win_oh[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    paddr_sel  = '0;
    pwdata_sel = '0;
    pwrite_sel = 1'b0;
    for (int j = 0; j < NUM_M; j++) begin
      if (win_oh[j]) begin
        paddr_sel  = m_paddr_i[j*ADDR_W +: ADDR_W];
        pwdata_sel = m_pwdata_i[j*DATA_W +: DATA_W];
        pwrite_sel = m_pwrite_i[j];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loaded in SETUP so that the TIMEOUT_CYC-th ACCESS cycle sees zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SETUP) begin
      cnt_d = CNT_W'(TIMEOUT_CYC - 1);
    end else if (state_q == S_ACCESS && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign timeout   = (state_q == S_ACCESS) && !s_pready_i && (cnt_q == '0);
  assign timeout_o = timeout;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  assign done = (state_q == S_ACCESS) && (s_pready_i || timeout);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_SETUP;
          gidx_d   = win_idx;
          grant_d  = win_oh;
          paddr_d  = paddr_sel;
          pwdata_d = pwdata_sel;
          pwrite_d = pwrite_sel;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (done) begin
          state_d = S_IDLE;
          ptr_d   = gidx_q;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  assign s_psel_o    = (state_q != S_IDLE) && !timeout;
  assign s_penable_o = (state_q == S_ACCESS) && !timeout;
  assign s_pwrite_o  = pwrite_q;
  assign s_paddr_o   = paddr_q;
  assign s_pwdata_o  = pwdata_q;
  assign m_prdata_o  = s_prdata_i;
  assign m_pready_o  = done ? grant_q : '0;
  assign m_pslverr_o = (done && (s_pslverr_i || timeout)) ? grant_q : '0;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter (default build, two masters).
// Inputs change and outputs are sampled on the falling edge of pclk.
module tb_apb_arbiter;

  logic        pclk = 1'b0;
  logic        preset;
  logic [1:0]  m_psel, m_penable, m_pwrite;
  logic [15:0] m_paddr;
  logic [63:0] m_pwdata;
  logic [31:0] m_prdata;
  logic [1:0]  m_pready, m_pslverr;
  logic        s_psel, s_penable, s_pwrite;
  logic [7:0]  s_paddr;
  logic [31:0] s_pwdata, s_prdata;
  logic        s_pready, s_pslverr;
  logic [1:0]  grant;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [1:0] exp_g [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

  always #5 pclk = ~pclk;

  apb_arbiter dut (
    .pclk_i      (pclk),
    .preset_i    (preset),
    .m_psel_i    (m_psel),
    .m_penable_i (m_penable),
    .m_pwrite_i  (m_pwrite),
    .m_paddr_i   (m_paddr),
    .m_pwdata_i  (m_pwdata),
    .m_prdata_o  (m_prdata),
    .m_pready_o  (m_pready),
    .m_pslverr_o (m_pslverr),
    .s_psel_o    (s_psel),
    .s_penable_o (s_penable),
    .s_pwrite_o  (s_pwrite),
    .s_paddr_o   (s_paddr),
    .s_pwdata_o  (s_pwdata),
    .s_prdata_i  (s_prdata),
    .s_pready_i  (s_pready),
    .s_pslverr_i (s_pslverr),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  initial begin
    preset    = 1'b1;
    m_psel    = '0;
    m_penable = '0;
    m_pwrite  = '0;
    m_paddr   = '0;
    m_pwdata  = '0;
    s_prdata  = '0;
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_psel", s_psel, 1'b0);
    chk("rst_m_pready", m_pready, 2'b00);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;

    // single master read
    m_psel[0]    = 1'b1;
    m_paddr[7:0] = 8'h10;
    s_pready     = 1'b1;
    s_prdata     = 32'hDEADBEEF;
    chk("t1_idle_s_psel", s_psel, 1'b0);
    chk("t1_idle_m_pready", m_pready, 2'b00);
    tick();
    chk("t1_setup_grant", grant, 2'b01);
    chk("t1_setup_s_psel", s_psel, 1'b1);
    chk("t1_setup_s_penable", s_penable, 1'b0);
    chk("t1_setup_s_paddr", s_paddr, 8'h10);
    chk("t1_setup_m_pready", m_pready, 2'b00);
    m_penable[0] = 1'b1;
    tick();
    chk("t1_access_s_psel", s_psel, 1'b1);
    chk("t1_access_s_penable", s_penable, 1'b1);
    chk("t1_access_m_pready", m_pready, 2'b01);
    chk("t1_access_m_prdata", m_prdata, 32'hDEADBEEF);
    m_psel    = '0;
    m_penable = '0;
    tick();
    chk("t1_done_busy", busy, 1'b0);
    chk("t1_done_grant", grant, 2'b00);
    chk("t1_done_s_psel", s_psel, 1'b0);

    // simultaneous requests: master 1 first, then master 0
    m_psel        = 2'b11;
    m_paddr[7:0]  = 8'h20;
    m_paddr[15:8] = 8'h31;
    tick();
    chk("t2_first_grant", grant, 2'b10);
    chk("t2_first_s_paddr", s_paddr, 8'h31);
    m_penable = 2'b11;
    tick();
    chk("t2_first_m_pready", m_pready, 2'b10);
    m_psel[1]    = 1'b0;
    m_penable[1] = 1'b0;
    tick();
    chk("t2_gap_grant", grant, 2'b00);
    chk("t2_gap_m_pready", m_pready, 2'b00);
    tick();
    chk("t2_second_grant", grant, 2'b01);
    chk("t2_second_s_paddr", s_paddr, 8'h20);
    tick();
    chk("t2_second_m_pready", m_pready, 2'b01);
    m_psel    = '0;
    m_penable = '0;
    tick();

    // back-to-back contention over six transfers
    m_psel    = 2'b11;
    m_penable = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t3_setup_grant", grant, exp_g[k]);
      chk("t3_setup_m_pready", m_pready, 2'b00);
      tick();
      chk("t3_access_m_pready", m_pready, exp_g[k]);
      tick();
      chk("t3_idle_grant", grant, 2'b00);
    end
    m_psel    = '0;
    m_penable = '0;

    // slave wait states, then error completion
    s_pready       = 1'b0;
    m_psel[0]      = 1'b1;
    m_pwrite[0]    = 1'b1;
    m_paddr[7:0]   = 8'h44;
    m_pwdata[31:0] = 32'hCAFE0001;
    tick();
    chk("t4_setup_grant", grant, 2'b01);
    chk("t4_setup_s_pwrite", s_pwrite, 1'b1);
    chk("t4_setup_s_paddr", s_paddr, 8'h44);
    chk("t4_setup_s_pwdata", s_pwdata, 32'hCAFE0001);
    m_penable[0]   = 1'b1;
    m_paddr[7:0]   = 8'hFF;
    m_pwdata[31:0] = 32'h0;
    for (int w = 0; w < 4; w++) begin
      tick();
      chk("t4_wait_m_pready", m_pready, 2'b00);
      chk("t4_wait_m_pslverr", m_pslverr, 2'b00);
      chk("t4_wait_s_paddr", s_paddr, 8'h44);
      chk("t4_wait_s_pwdata", s_pwdata, 32'hCAFE0001);
    end
    s_pready  = 1'b1;
    s_pslverr = 1'b1;
    #1;
    chk("t4_done_m_pready", m_pready, 2'b01);
    chk("t4_done_m_pslverr", m_pslverr, 2'b01);
    chk("t4_done_s_paddr", s_paddr, 8'h44);
    m_psel    = '0;
    m_penable = '0;
    m_pwrite  = '0;
    tick();
    chk("t4_after_m_pslverr", m_pslverr, 2'b00);
    chk("t4_after_busy", busy, 1'b0);
    s_pslverr = 1'b0;

    // master 1 completes once so the pointer moves to 1
    m_psel[1]     = 1'b1;
    m_paddr[15:8] = 8'h51;
    tick();
    chk("t5_pre_grant", grant, 2'b10);
    tick();
    chk("t5_pre_m_pready", m_pready, 2'b10);
    m_psel = '0;
    tick();

    // reset during an ACCESS wait state
    m_psel[1] = 1'b1;
    s_pready  = 1'b0;
    tick();
    tick();
    chk("t5_wait_busy", busy, 1'b1);
    chk("t5_wait_grant", grant, 2'b10);
    #2 preset = 1'b1;
    #1;
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_s_psel", s_psel, 1'b0);
    chk("t5_rst_s_penable", s_penable, 1'b0);
    chk("t5_rst_s_paddr", s_paddr, 8'h00);
    chk("t5_rst_s_pwrite", s_pwrite, 1'b0);
    chk("t5_rst_s_pwdata", s_pwdata, 32'h0);
    chk("t5_rst_m_pready", m_pready, 2'b00);
    chk("t5_rst_m_pslverr", m_pslverr, 2'b00);
    @(negedge pclk);
    preset   = 1'b0;
    m_psel   = 2'b11;
    s_pready = 1'b1;
    tick();
    chk("t5_post_grant", grant, 2'b10);
    tick();
    chk("t5_post_m_pready", m_pready, 2'b10);
    m_psel = '0;
    tick();
    chk("t5_post_idle_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
